// File: rtl/mips_pkg.sv
// Shared definitions for the branch redirect path: FSM encoding, link register
// index and PC increment, plus the return-address helper.
package mips_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_SQUASH = 2'd2
   } br_state_e;

   localparam logic [4:0]  REG_RA  = 5'd31;
   localparam logic [31:0] PC_STEP = 32'd4;

   // With a delay slot the instruction after the branch executes, so the
   // link skips over it. The add wraps modulo 2^32.
   function automatic logic [31:0] return_addr(input logic [31:0] pc, input bit delay_slot);
      return delay_slot ? pc + (PC_STEP << 1) : pc + PC_STEP;
   endfunction

endpackage

// File: rtl/branch_redirect_unit_if.sv
// Bundle between branch resolution and the fetch/decode/regfile consumers.
// master = branch resolution side; slave = branch_redirect_unit.
interface branch_redirect_unit_if #(parameter int CNT_W = 16);

   logic             br_valid;
   logic             br_taken;
   logic             br_link;
   logic [31:0]      br_pc;
   logic [31:0]      br_target;
   logic             stall;
   logic             cnt_clr;
   logic             pc_sel;
   logic [31:0]      pc_target;
   logic             if_id_flush;
   logic             link_we;
   logic [4:0]       link_addr;
   logic [31:0]      link_data;
   logic [CNT_W-1:0] br_total;
   logic [CNT_W-1:0] br_taken_cnt;

   modport master (
      output br_valid, br_taken, br_link, br_pc, br_target, stall, cnt_clr,
      input  pc_sel, pc_target, if_id_flush, link_we, link_addr, link_data,
             br_total, br_taken_cnt
   );

   modport slave (
      input  br_valid, br_taken, br_link, br_pc, br_target, stall, cnt_clr,
      output pc_sel, pc_target, if_id_flush, link_we, link_addr, link_data,
             br_total, br_taken_cnt
   );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (inc && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + 1'b1;
   end

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/branch_redirect_unit.sv
// Turns a resolved branch into PC redirect, IF/ID flush and $31 link write,
// and keeps saturating branch statistics.
module branch_redirect_unit
   import mips_pkg::*;
#(
   parameter int DELAY_SLOT = 1,
   parameter int CNT_W      = 16
) (
   input logic                   clk,
   input logic                   reset,
   branch_redirect_unit_if.slave bus
);

   localparam bit HAS_SLOT = (DELAY_SLOT != 0);

   br_state_e   state_q, state_d;
   logic        taken_q, taken_d;
   logic        link_q, link_d;
   logic [31:0] target_q, target_d;
   logic [31:0] ret_q, ret_d;
   logic        accept;

   assign accept = (state_q == ST_IDLE) && bus.br_valid;

   always_comb begin
      state_d  = state_q;
      taken_d  = taken_q;
      link_d   = link_q;
      target_d = target_q;
      ret_d    = ret_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.br_valid) begin
               taken_d  = bus.br_taken;
               link_d   = bus.br_link;
               target_d = bus.br_target;
               ret_d    = return_addr(bus.br_pc, HAS_SLOT);
               if (bus.br_taken || bus.br_link)
                  state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (!bus.stall)
               state_d = taken_q ? ST_SQUASH : ST_IDLE;
         end
         ST_SQUASH: begin
            if (!bus.stall)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: only control/latch flops are reset here; there is no memory array to clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         taken_q  <= 1'b0;
         link_q   <= 1'b0;
         target_q <= '0;
         ret_q    <= '0;
      end else begin
         state_q  <= state_d;
         taken_q  <= taken_d;
         link_q   <= link_d;
         target_q <= target_d;
         ret_q    <= ret_d;
      end
   end

   // Outputs depend only on flopped state, so a stall or reset needs no extra gating.
   always_comb begin
      bus.pc_sel      = 1'b0;
      bus.pc_target   = '0;
      bus.if_id_flush = 1'b0;
      bus.link_we     = 1'b0;
      bus.link_addr   = REG_RA;
      bus.link_data   = '0;
      case (state_q)
         ST_ISSUE: begin
            bus.pc_sel      = taken_q;
            bus.pc_target   = target_q;
            bus.if_id_flush = taken_q && !HAS_SLOT;
            bus.link_we     = link_q;
            bus.link_data   = link_q ? ret_q : 32'd0;
         end
         ST_SQUASH: bus.if_id_flush = 1'b1;
         default: ;
      endcase
   end

   sat_counter #(.CNT_W(CNT_W)) u_total_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (accept),
      .clr   (bus.cnt_clr),
      .cnt   (bus.br_total)
   );

   sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (accept && bus.br_taken),
      .clr   (bus.cnt_clr),
      .cnt   (bus.br_taken_cnt)
   );

endmodule
